// File: rtl/jt6295_pkg.sv
// Shared constants and slot FSM encoding for the jt6295 voice mixer.
package jt6295_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } slot_state_e;

endpackage

// File: rtl/jt6295_slotmix.sv
// Time-multiplexed four-voice mixer: requests one sample per slot on each
// cen_sr4 strobe and publishes the exact sum on every cen_sr.
module jt6295_slotmix
    import jt6295_pkg::*;
#(
    parameter int SW = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen_sr,
    input  logic                 cen_sr4,
    output logic [SLOT_W-1:0]    slot,
    output logic                 slot_req,
    input  logic                 slot_valid,
    input  logic signed [SW-1:0] slot_data,
    output logic signed [SW+1:0] sound,
    output logic                 sample,
    output logic                 miss,
    output logic                 sync_err
);

    // Handshake: slot_req stays high while slot `slot` is open; a sample moves
    // on any clk where slot_req && slot_valid; slot_valid alone does nothing.

    slot_state_e           state_q, state_d;
    logic                  synced_q, synced_d;
    logic [SLOT_W-1:0]     slot_d;
    logic signed [SW+1:0]  acc_q, acc_d;
    logic signed [SW+1:0]  sound_d;
    logic                  sample_d, miss_d, sync_err_d;

    logic                  xfer;
    logic                  strobe;
    logic signed [SW+1:0]  addend;
    logic signed [SW+1:0]  sum;

    assign slot_req = (state_q == ST_REQ);

    always_comb begin
        xfer       = (state_q == ST_REQ) && slot_valid;
        strobe     = cen_sr4 || cen_sr;
        addend     = xfer ? {{2{slot_data[SW-1]}}, slot_data} : '0;
        sum        = acc_q + addend;

        state_d    = state_q;
        synced_d   = synced_q;
        slot_d     = slot;
        acc_d      = acc_q;
        sound_d    = sound;
        sample_d   = 1'b0;
        miss_d     = 1'b0;
        sync_err_d = 1'b0;

        if (!synced_q) begin
            // The syncing cen_sr only opens slot 0; there is no prior period to publish.
            if (cen_sr) begin
                synced_d = 1'b1;
                slot_d   = '0;
                state_d  = ST_REQ;
                acc_d    = '0;
            end
        end else if (strobe) begin
            // A same-cycle transfer belongs to the closing slot, so `sum` already holds it.
            miss_d  = (state_q == ST_REQ) && !xfer;
            state_d = ST_REQ;
            if (cen_sr) begin
                sound_d    = sum;
                sample_d   = 1'b1;
                acc_d      = '0;
                slot_d     = '0;
                sync_err_d = (slot != LAST_SLOT);
            end else begin
                acc_d      = sum;
                slot_d     = slot + SLOT_W'(1);
                sync_err_d = (slot == LAST_SLOT);
            end
        end else begin
            acc_d = sum;
            if (xfer) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            synced_q <= 1'b0;
            slot     <= '0;
            acc_q    <= '0;
            sound    <= '0;
            sample   <= 1'b0;
            miss     <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state_q  <= state_d;
            synced_q <= synced_d;
            slot     <= slot_d;
            acc_q    <= acc_d;
            sound    <= sound_d;
            sample   <= sample_d;
            miss     <= miss_d;
            sync_err <= sync_err_d;
        end
    end

endmodule

// File: tb/tb_jt6295_slotmix.sv
// Bench for jt6295_slotmix: strobe generator, voice-engine responder and a
// per-period sum model feeding an expected-sound queue.
module tb_jt6295_slotmix;
    import jt6295_pkg::*;

    localparam int SW          = 12;
    localparam int STROBE_CLKS = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cen_sr;
    logic                 cen_sr4;
    logic [SLOT_W-1:0]    slot;
    logic                 slot_req;
    logic                 slot_valid;
    logic [SW-1:0]        slot_data;
    logic [SW+1:0]        sound;
    logic                 sample;
    logic                 miss;
    logic                 sync_err;

    always #5 clk = ~clk;

    jt6295_slotmix #(.SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen_sr     (cen_sr),
        .cen_sr4    (cen_sr4),
        .slot       (slot),
        .slot_req   (slot_req),
        .slot_valid (slot_valid),
        .slot_data  (slot_data),
        .sound      (sound),
        .sample     (sample),
        .miss       (miss),
        .sync_err   (sync_err)
    );

    // Voice engine configuration, changed only between periods.
    logic signed [SW-1:0] val [SLOTS];
    logic                 ans_en [SLOTS];
    int                   eng_lat;
    logic                 noise;

    int                   n_cmp, n_bad;
    logic [SW+1:0]        exp_q[$];
    int                   miss_cnt, sync_cnt, samp_cnt;
    int                   miss_exp, sync_exp, samp_exp;
    bit                   synced_m, pend_short, pend_miss;

    // Engine: answers `eng_lat` clks after a slot opens; random chatter otherwise.
    initial begin
        int            eng_cnt;
        logic          eng_busy;
        logic [SLOT_W-1:0] eng_slot;
        slot_valid = 1'b0;
        slot_data  = '0;
        eng_cnt    = 0;
        eng_busy   = 1'b0;
        eng_slot   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (slot_req) begin
                if (!eng_busy || slot != eng_slot) begin
                    eng_busy = 1'b1;
                    eng_slot = slot;
                    eng_cnt  = 0;
                end
                if (ans_en[slot] && eng_cnt == eng_lat) begin
                    slot_valid = 1'b1;
                    slot_data  = val[slot];
                end else begin
                    slot_valid = 1'b0;
                    slot_data  = SW'($urandom);
                end
                eng_cnt++;
            end else begin
                eng_busy   = 1'b0;
                slot_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                slot_data  = SW'($urandom);
            end
        end
    end

    task automatic check(input string tag, input logic [SW+1:0] obs, input logic [SW+1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (sample) begin
            samp_cnt++;
            if (exp_q.size() > 0) check("sound", sound, exp_q.pop_front());
            else check("sample_unexpected", 14'(sample), 14'd0);
        end
        if (miss) miss_cnt++;
        if (sync_err) sync_cnt++;
    endtask

    task automatic clk_cycle(input logic s4, input logic sr);
        cen_sr4 = s4;
        cen_sr  = sr;
        step();
    endtask

    task automatic do_reset(input logic strobe_too);
        rst     = 1'b1;
        cen_sr4 = strobe_too;
        cen_sr  = strobe_too;
        step();
        check("rst_slot", 14'(slot), 14'd0);
        check("rst_slot_req", 14'(slot_req), 14'd0);
        check("rst_sound", sound, 14'd0);
        check("rst_sample", 14'(sample), 14'd0);
        check("rst_miss", 14'(miss), 14'd0);
        check("rst_sync_err", 14'(sync_err), 14'd0);
        rst = 1'b0;
        exp_q.delete();
        synced_m   = 1'b0;
        pend_short = 1'b0;
        pend_miss  = 1'b0;
    endtask

    // One output period of n slot strobes; the last slot is followed by `tail` idle clks.
    task automatic run_period(input int n, input int tail);
        int sum;
        int s;
        int lim;
        sum = 0;
        if (synced_m) begin
            samp_exp++;
            if (pend_short) sync_exp++;
            if (pend_miss) miss_exp++;
        end
        synced_m = 1'b1;
        for (int k = 0; k < n; k++) begin
            s = k % SLOTS;
            if (k > 0 && s == 0) sync_exp++;
            if (ans_en[s]) sum += int'(val[s]);
            else if (k < n - 1) miss_exp++;
            clk_cycle(1'b1, k == 0);
            check("slot_idx", 14'(slot), 14'(s));
            check("slot_req_open", 14'(slot_req), 14'd1);
            lim = (k == n - 1) ? tail : STROBE_CLKS - 1;
            for (int i = 0; i < lim; i++) clk_cycle(1'b0, 1'b0);
        end
        pend_short = ((n - 1) % SLOTS) != SLOTS - 1;
        pend_miss  = !ans_en[(n - 1) % SLOTS];
        exp_q.push_back((SW+2)'(sum));
    endtask

    task automatic checkpoint(input string tag);
        check({tag, "_miss_cnt"}, 14'(miss_cnt), 14'(miss_exp));
        check({tag, "_sync_cnt"}, 14'(sync_cnt), 14'(sync_exp));
        check({tag, "_sample_cnt"}, 14'(samp_cnt), 14'(samp_exp));
    endtask

    task automatic set_all(input logic signed [SW-1:0] v);
        for (int j = 0; j < SLOTS; j++) begin
            val[j]    = v;
            ans_en[j] = 1'b1;
        end
    endtask

    initial begin
        int base;
        int new_sum;
        n_cmp = 0; n_bad = 0;
        miss_cnt = 0; sync_cnt = 0; samp_cnt = 0;
        miss_exp = 0; sync_exp = 0; samp_exp = 0;
        synced_m = 1'b0; pend_short = 1'b0; pend_miss = 1'b0;
        rst = 1'b1; cen_sr = 1'b0; cen_sr4 = 1'b0;
        noise = 1'b0; eng_lat = 2;
        set_all('0);

        do_reset(1'b0);

        // Unsynced: cen_sr4 alone must not open a slot.
        clk_cycle(1'b1, 1'b0);
        check("unsynced_req", 14'(slot_req), 14'd0);
        for (int i = 0; i < 3; i++) clk_cycle(1'b0, 1'b0);
        clk_cycle(1'b1, 1'b0);
        check("unsynced_req2", 14'(slot_req), 14'd0);
        check("unsynced_slot", 14'(slot), 14'd0);

        // Nominal engine values.
        val[0] = 12'sd100; val[1] = -12'sd50; val[2] = 12'sd7; val[3] = 12'sd0;
        for (int p = 0; p < 4; p++) run_period(4, STROBE_CLKS - 1);
        check("sound_nominal", sound, 14'd57);
        checkpoint("nominal");

        // Extremes: exact sums with no wrap.
        set_all(12'sd2047);
        for (int p = 0; p < 2; p++) run_period(4, STROBE_CLKS - 1);
        check("sound_max", sound, 14'd8188);
        set_all(-12'sd2048);
        for (int p = 0; p < 2; p++) run_period(4, STROBE_CLKS - 1);
        check("sound_min", sound, 14'h2000);
        checkpoint("extremes");

        // Slot 2 never answered.
        set_all(12'sd10);
        ans_en[2] = 1'b0;
        base = miss_cnt;
        for (int p = 0; p < 3; p++) run_period(4, STROBE_CLKS - 1);
        check("sound_missing_slot", sound, 14'd30);
        check("miss_per_period", 14'(miss_cnt - base), 14'd3);
        checkpoint("missing");

        // Answer lands on the same clk as the next strobe.
        eng_lat = STROBE_CLKS - 1;
        for (int j = 0; j < SLOTS; j++) begin
            val[j]    = SW'($urandom_range(0, 4095));
            ans_en[j] = 1'b1;
        end
        for (int p = 0; p < 3; p++) run_period(4, STROBE_CLKS - 1);
        checkpoint("late_answer");

        // Random values, latencies and dropouts with chatter on slot_valid.
        noise = 1'b1;
        for (int p = 0; p < 8; p++) begin
            for (int j = 0; j < SLOTS; j++) begin
                val[j]    = SW'($urandom_range(0, 4095));
                ans_en[j] = ($urandom_range(0, 3) != 0);
            end
            eng_lat = $urandom_range(0, STROBE_CLKS - 1);
            run_period(4, STROBE_CLKS - 1);
        end
        checkpoint("random");
        noise = 1'b0;

        // Long then short period.
        eng_lat = 2;
        val[0] = 12'sd1; val[1] = 12'sd20; val[2] = -12'sd300; val[3] = 12'sd4000 - 12'sd4000 + 12'sd5;
        for (int j = 0; j < SLOTS; j++) ans_en[j] = 1'b1;
        base = sync_cnt;
        run_period(5, STROBE_CLKS - 1);
        run_period(3, STROBE_CLKS - 1);
        run_period(4, STROBE_CLKS - 1);
        run_period(4, STROBE_CLKS - 1);
        check("sync_err_count", 14'(sync_cnt - base), 14'd3);
        checkpoint("sync");

        // Reset while slot 3 is open, coinciding with its transfer and a strobe.
        val[0] = 12'sd300; val[1] = 12'sd200; val[2] = 12'sd100; val[3] = 12'sd50;
        for (int p = 0; p < 2; p++) run_period(4, STROBE_CLKS - 1);
        run_period(4, 2);
        check("pre_rst_req", 14'(slot_req), 14'd1);
        check("pre_rst_slot", 14'(slot), 14'd3);
        check("pre_rst_sound", sound, 14'd650);
        do_reset(1'b1);
        clk_cycle(1'b1, 1'b0);
        check("post_rst_unsynced", 14'(slot_req), 14'd0);
        for (int i = 0; i < 3; i++) clk_cycle(1'b0, 1'b0);
        new_sum = 0;
        for (int j = 0; j < SLOTS; j++) begin
            val[j] = SW'($urandom_range(0, 4095));
            new_sum += int'(val[j]);
        end
        for (int p = 0; p < 2; p++) run_period(4, STROBE_CLKS - 1);
        check("sound_after_resync", sound, (SW+2)'(new_sum));
        checkpoint("reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jt6295_slotmix.md
JT6295_SLOTMIX -- requirements
Module: jt6295_slotmix

Interface
REQ-001 Parameter: SW, 12, signed sample width per voice slot.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: cen_sr  input  1  sample-rate strobe, one clk wide; always coincides with a cen_sr4 pulse.
REQ-005 Port: cen_sr4  input  1  4x sample-rate strobe, one clk wide; 4 pulses per cen_sr period.
REQ-006 Port: slot  output  2  index of the voice slot currently serviced.
REQ-007 Port: slot_req  output  1  request for the sample of voice `slot`.
REQ-008 Port: slot_valid  input  1  voice engine presents slot_data; transfer when slot_req && slot_valid.
REQ-009 Port: slot_data  input  SW  signed voice sample.
REQ-010 Port: sound  output  SW+2  signed mixed sample, held between updates.
REQ-011 Port: sample  output  1  one-clk pulse when sound updates.
REQ-012 Port: miss  output  1  one-clk pulse when a slot closes without a transfer.
REQ-013 Port: sync_err  output  1  one-clk pulse on strobe pattern violation.

Function
REQ-014 Block is unsynced after reset; it ignores cen_sr4 until the first cen_sr, which syncs it.
REQ-015 Slot FSM states: IDLE (unsynced, or slot done), REQ (slot_req=1, waiting), DONE (sample taken, waiting next strobe).
REQ-016 Strobe cycle (cen_sr4=1, synced): slot advances (0 on cen_sr, else slot+1); FSM enters REQ; slot_req goes high the following clk.
REQ-017 In REQ, a transfer adds sign-extended slot_data to a (SW+2)-bit accumulator; FSM goes to DONE; slot_req drops the next clk.
REQ-018 Strobe arriving while in REQ without a transfer that cycle: closing slot contributes 0; miss pulses next clk.
REQ-019 Transfer and strobe in same clk: transfer is counted for the closing slot; no miss; then the strobe is processed.
REQ-020 On cen_sr: sound <= accumulator + same-cycle transfer; accumulator restarts at 0; sample pulses; both visible the clk after cen_sr.
REQ-021 Sum of 4 SW-bit values is exact in SW+2 bits; no saturation, no wrap possible.
REQ-022 cen_sr arriving when the last opened slot is not 3 (short period): sync_err pulses; output still updates; slot restarts at 0.
REQ-023 cen_sr4 without cen_sr when slot is 3 (long period): sync_err pulses; slot wraps to 0; accumulation continues, no output.
REQ-024 slot_valid outside REQ is ignored; slot_data is sampled only on transfer.
REQ-025 Strobes with both inputs low between pulses leave all state unchanged.

Reset
REQ-026 rst clears: slot=0, slot_req=0, sound=0, sample=0, miss=0, sync_err=0, accumulator=0, FSM=IDLE, unsynced.
REQ-027 rst mid-request drops slot_req the next clk; a pending transfer is discarded.
REQ-028 rst takes priority over every strobe and transfer in the same clk.

Structure
REQ-029 Shared package jt6295_pkg holds the FSM state encoding and the slot count constant (4).
REQ-030 Single module, no sub-modules; the accumulator and FSM are local.

Verification
REQ-031 Drive with the sample-rate generator at ss=1; engine returns 100, -50, 7, 0 for slots 0..3, 2 clk latency -> sound=57 the clk after each cen_sr; sample pulses once per period; no miss or sync_err.
REQ-032 All four slots return 2047 -> sound=8188; all return -2048 -> sound=-8192 (exact, no wrap).
REQ-033 Engine never answers slot 2, others return 10 -> slot 2 contributes 0; miss pulses once per period; sound=30.
REQ-034 slot_valid arrives in the same clk as the next strobe -> sample counted; no miss.
REQ-035 Inject a 5th cen_sr4 before cen_sr -> sync_err on the wrap; omit one cen_sr4 -> sync_err at cen_sr; output period continues.
REQ-036 Assert rst while slot_req=1 with 3 slots accumulated -> all outputs 0 the next clk; unsynced until the next cen_sr; the first sound after resync has no stale contribution.
